// File: rtl/cache_pkg.sv
// Shared types and widths for the 2-way set-associative data cache.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package cache_pkg;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int SET_W    = 2;
  localparam int TAG_W    = ADDR_W - SET_W - 2;
  localparam int NUM_SETS = 1 << SET_W;
  localparam int NUM_WAYS = 2;

  typedef struct packed {
    logic valid;
    logic dirty;
  } cache_flags_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    cache_flags_t      flags;
  } cache_entry_t;

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, REFILL} cache_state_t;

  // Word-aligned line address rebuilt from a tag and a set index
  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [SET_W-1:0] set);
    return {tag, set, 2'b00};
  endfunction
endpackage

// File: rtl/cache_store.sv
// Tag/data/flag storage: 2 ways x NUM_SETS entries, both ways of one set readable.
// Latency: combinational read, write takes effect at the next clock edge.
// Backpressure: none; a write is accepted every cycle we_i is high.
module cache_store
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [SET_W-1:0] rd_set_i,
  output cache_entry_t     rd_way0_o,
  output cache_entry_t     rd_way1_o,
  input  logic             we_i,
  input  logic             wr_way_i,
  input  logic [SET_W-1:0] wr_set_i,
  input  cache_entry_t     wr_entry_i
);
  logic [NUM_WAYS-1:0][NUM_SETS-1:0][DATA_W-1:0] data_q;
  logic [NUM_WAYS-1:0][NUM_SETS-1:0][TAG_W-1:0]  tag_q;
  cache_flags_t [NUM_WAYS-1:0][NUM_SETS-1:0]     flags_q;

  // Payload needs no reset: it is only looked at when the valid flag is set
  always_ff @(posedge clk) begin
    if (we_i) begin
      data_q[wr_way_i][wr_set_i] <= wr_entry_i.data;
      tag_q[wr_way_i][wr_set_i]  <= wr_entry_i.tag;
    end
  end

  // Flags reset to invalid/clean, so a reset empties the whole cache
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else if (we_i) begin
      flags_q[wr_way_i][wr_set_i] <= wr_entry_i.flags;
    end
  end

  // Present both ways of the addressed set for tag compare and victim choice
  always_comb begin
    rd_way0_o.data  = data_q[0][rd_set_i];
    rd_way0_o.tag   = tag_q[0][rd_set_i];
    rd_way0_o.flags = flags_q[0][rd_set_i];
    rd_way1_o.data  = data_q[1][rd_set_i];
    rd_way1_o.tag   = tag_q[1][rd_set_i];
    rd_way1_o.flags = flags_q[1][rd_set_i];
  end
endmodule

// File: rtl/cache_controller.sv
// Write-back/write-allocate controller for the 2-way data cache; CACHE_STATS_EN adds hit/miss counters.
// Latency: hit ready 2 cycles after acceptance; misses add one memory transaction (two if victim dirty).
// Backpressure: CPU request held until cpu_ready_o; memory req/addr/data held stable until mem_ack_i.
module cache_controller
  import cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SET_WIDTH     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req_i,
  input  logic                     cpu_we_i,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata_i,
  output logic                     cpu_ready_o,
  output logic [DATA_WIDTH-1:0]    cpu_rdata_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]    mem_wdata_o,
  input  logic                     mem_ack_i,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_i
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]              hit_count_o,
  output logic [31:0]              miss_count_o
`endif
);
  localparam int TAG_WIDTH = ADDRESS_WIDTH - SET_WIDTH - 2;

  cache_state_t                  state_q, state_d;
  logic [ADDRESS_WIDTH-3:0]      addr_q, addr_d;
  logic                          we_q, we_d;
  logic [DATA_WIDTH-1:0]         wdata_q, wdata_d;
  logic [(1<<SET_WIDTH)-1:0]     lru_q, lru_d;
  logic                          victim_q, victim_d;
  logic                          first_q, first_d;
  logic                          ready_q, ready_d;
  logic [DATA_WIDTH-1:0]         rdata_q, rdata_d;

  logic [SET_WIDTH-1:0]          set_w;
  logic [TAG_WIDTH-1:0]          tag_w;
  cache_entry_t                  way0, way1, hit_entry, sel_entry, cur_victim, wr_entry;
  logic                          hit0, hit1, hit, hit_way, victim_sel;
  logic                          st_we, st_way;
  logic                          unused_addr_bits;

  // Byte offset never matters: the cache holds one word per line
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign set_w = addr_q[SET_WIDTH-1:0];
  assign tag_w = addr_q[ADDRESS_WIDTH-3:SET_WIDTH];

  cache_store u_store (
    .clk        (clk),
    .rst        (rst),
    .rd_set_i   (set_w),
    .rd_way0_o  (way0),
    .rd_way1_o  (way1),
    .we_i       (st_we),
    .wr_way_i   (st_way),
    .wr_set_i   (set_w),
    .wr_entry_i (wr_entry)
  );

  assign hit0       = way0.flags.valid && (way0.tag == tag_w);
  assign hit1       = way1.flags.valid && (way1.tag == tag_w);
  assign hit        = hit0 || hit1;
  assign hit_way    = !hit0;
  assign hit_entry  = hit0 ? way0 : way1;
  // Fill empty ways first (way0 before way1), otherwise evict the LRU way
  assign victim_sel = !way0.flags.valid ? 1'b0 : (!way1.flags.valid ? 1'b1 : lru_q[set_w]);
  assign sel_entry  = victim_sel ? way1 : way0;
  assign cur_victim = victim_q ? way1 : way0;

  // Next-state, store write port and memory-side outputs
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    lru_d       = lru_q;
    victim_d    = victim_q;
    first_d     = first_q;
    ready_d     = 1'b0;
    rdata_d     = '0;
    st_we       = 1'b0;
    st_way      = victim_q;
    wr_entry    = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        if (cpu_req_i) begin
          addr_d  = cpu_addr_i[ADDRESS_WIDTH-1:2];
          we_d    = cpu_we_i;
          wdata_d = cpu_wdata_i;
          first_d = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        first_d = 1'b0;
        if (hit) begin
          ready_d       = 1'b1;
          lru_d[set_w]  = ~hit_way;
          state_d       = IDLE;
          if (we_q) begin
            st_we          = 1'b1;
            st_way         = hit_way;
            wr_entry.data  = wdata_q;
            wr_entry.tag   = tag_w;
            wr_entry.flags = '{valid: 1'b1, dirty: 1'b1};
          end else begin
            rdata_d = hit_entry.data;
          end
        end else begin
          victim_d = victim_sel;
          state_d  = (sel_entry.flags.valid && sel_entry.flags.dirty) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = line_addr(cur_victim.tag, set_w);
        mem_wdata_o = cur_victim.data;
        if (mem_ack_i) begin
          st_we                = 1'b1;
          wr_entry             = cur_victim;
          wr_entry.flags.dirty = 1'b0;
          state_d              = REFILL;
        end
      end
      REFILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = line_addr(tag_w, set_w);
        if (mem_ack_i) begin
          st_we          = 1'b1;
          wr_entry.data  = mem_rdata_i;
          wr_entry.tag   = tag_w;
          wr_entry.flags = '{valid: 1'b1, dirty: 1'b0};
          state_d        = LOOKUP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      lru_q    <= '0;
      victim_q <= 1'b0;
      first_q  <= 1'b0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      lru_q    <= lru_d;
      victim_q <= victim_d;
      first_q  <= first_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
    end
  end

  assign cpu_ready_o = ready_q;
  assign cpu_rdata_o = rdata_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;

  // Saturating counters, bumped only on the first lookup of each access
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (state_q == LOOKUP && first_q) begin
      if (hit && hit_count_q != 32'hFFFF_FFFF) hit_count_q <= hit_count_q + 32'd1;
      if (!hit && miss_count_q != 32'hFFFF_FFFF) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count_o  = hit_count_q;
  assign miss_count_o = miss_count_q;
`endif
endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed scenarios plus randomized accesses against a cache/memory model.
// Latency: checks 2-cycle hits and exact miss latency with a fixed ack delay.
// Backpressure: the bench is the memory, acking after a random delay and checking output stability.
`timescale 1ns/1ps
module tb_cache_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_i, cpu_we_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i;
  logic        cpu_ready_o;
  logic [31:0] cpu_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_o, miss_count_o;
`endif

  always #5 clk = ~clk;

  cache_controller dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_ready_o(cpu_ready_o), .cpu_rdata_o(cpu_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
`ifdef CACHE_STATS_EN
    , .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
`endif
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: cache contents per set/way, LRU per set, backing memory by line address
  bit          m_valid [4][2];
  bit          m_dirty [4][2];
  logic [27:0] m_tag   [4][2];
  logic [31:0] m_data  [4][2];
  bit          m_lru   [4];
  logic [31:0] backing [logic [31:0]];
  int          m_hits, m_misses;
  txn_t        exp_q[$];
  txn_t        obs_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] line);
    if (!backing.exists(line)) backing[line] = $urandom;
    return backing[line];
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 4; s++) begin
      m_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
    m_hits = 0;
    m_misses = 0;
  endfunction

  // Apply one access to the model: expected memory traffic goes to exp_q
  function automatic void model_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic [31:0] rdata, output bit hit);
    int          s;
    int          way;
    logic [27:0] t;
    txn_t        tx;
    s = int'(addr[3:2]);
    t = addr[31:4];
    way = -1;
    exp_q.delete();
    for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_tag[s][w] == t) way = w;
    hit = (way >= 0);
    if (!hit) begin
      if (!m_valid[s][0]) way = 0;
      else if (!m_valid[s][1]) way = 1;
      else way = int'(m_lru[s]);
      if (m_valid[s][way] && m_dirty[s][way]) begin
        tx.we = 1'b1;
        tx.addr = {m_tag[s][way], addr[3:2], 2'b00};
        tx.wdata = m_data[s][way];
        exp_q.push_back(tx);
        backing[tx.addr] = m_data[s][way];
      end
      tx.we = 1'b0;
      tx.addr = {t, addr[3:2], 2'b00};
      tx.wdata = '0;
      exp_q.push_back(tx);
      m_valid[s][way] = 1'b1;
      m_dirty[s][way] = 1'b0;
      m_tag[s][way] = t;
      m_data[s][way] = mem_word(tx.addr);
    end
    rdata = m_data[s][way];
    if (we) begin
      m_data[s][way] = wdata;
      m_dirty[s][way] = 1'b1;
    end
    m_lru[s] = (way == 0);
    if (hit) m_hits++;
    else m_misses++;
  endfunction

  // Drive one CPU access and act as memory; records traffic in obs_q and protocol violations in viol
  task automatic run_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                            input int dmin, input int dmax, input bit stray,
                            output logic [31:0] rdata, output int latency, output int viol, output bit timeout);
    bit   in_txn;
    int   wait_cnt, delay;
    txn_t cur;
    in_txn = 0; wait_cnt = 0; delay = 0; cur = '0;
    obs_q.delete();
    viol = 0; latency = 0; timeout = 1; rdata = '0;
    @(negedge clk);
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wdata;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk); #1;
      if (mem_ack_i) begin
        mem_ack_i = 1'b0;
        in_txn = 0;
      end
      if (cpu_ready_o) begin
        latency = cyc; rdata = cpu_rdata_o; timeout = 0;
        if (mem_req_o) viol++;
        cpu_req_i = 1'b0;
        break;
      end
      if (mem_req_o) begin
        if (!in_txn) begin
          in_txn = 1;
          cur = {mem_we_o, mem_addr_o, mem_wdata_o};
          obs_q.push_back(cur);
          wait_cnt = 0;
          delay = $urandom_range(dmax, dmin);
        end else if ({mem_we_o, mem_addr_o, mem_wdata_o} !== cur) begin
          viol++;
        end
        if (wait_cnt == delay) begin
          mem_ack_i = 1'b1;
          mem_rdata_i = mem_we_o ? $urandom : mem_word(mem_addr_o);
        end
        wait_cnt++;
      end else begin
        if (in_txn) viol++;
        if (stray) begin
          mem_ack_i = 1'($urandom_range(1, 0));
          mem_rdata_i = $urandom;
        end
      end
    end
    cpu_req_i = 1'b0;
    mem_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_wdata_i = '0; mem_ack_i = 0; mem_rdata_i = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({cpu_ready_o, cpu_rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: ready=%b rdata=%h req=%b we=%b addr=%h wdata=%h, required all zero",
               cpu_ready_o, cpu_rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
    end
`ifdef CACHE_STATS_EN
    vectors++;
    if (hit_count_o !== 0 || miss_count_o !== 0) begin
      miscompares++;
      $display("FAIL reset_stats: hits=%0d misses=%0d, required 0/0", hit_count_o, miss_count_o);
    end
`endif
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] addrs [6];
    bit          wes [6];
    logic [31:0] rd, exp_rd;
    bit          exp_hit, tmo;
    int          lat, viol;
    addrs = '{32'h10, 32'h10, 32'h20, 32'h20, 32'h00, 32'h10};
    wes   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    backing[32'h10] = 32'hDEADBEEF;
    for (int i = 0; i < 6; i++) begin
      model_access(wes[i], addrs[i], 32'h12345678, exp_rd, exp_hit);
      run_access(wes[i], addrs[i], 32'h12345678, 0, 2, 1'b0, rd, lat, viol, tmo);
      vectors++;
      if (tmo) begin
        miscompares++;
        $display("FAIL dir%0d_timeout: no cpu_ready_o within 300 cycles, required completion", i);
      end
      vectors++;
      if (obs_q.size() != exp_q.size()) begin
        miscompares++;
        $display("FAIL dir%0d_txn_count: got %0d memory transactions, required %0d", i, obs_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[k]) begin
          vectors++;
          if (obs_q[k].we !== exp_q[k].we || obs_q[k].addr !== exp_q[k].addr ||
              (exp_q[k].we && obs_q[k].wdata !== exp_q[k].wdata)) begin
            miscompares++;
            $display("FAIL dir%0d_txn%0d: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h", i, k,
                     obs_q[k].we, obs_q[k].addr, obs_q[k].wdata, exp_q[k].we, exp_q[k].addr, exp_q[k].wdata);
          end
        end
      end
      if (!wes[i]) begin
        vectors++;
        if (rd !== exp_rd) begin
          miscompares++;
          $display("FAIL dir%0d_rdata: got %h, required %h", i, rd, exp_rd);
        end
      end
      if (exp_hit) begin
        vectors++;
        if (lat != 2) begin
          miscompares++;
          $display("FAIL dir%0d_hit_latency: got %0d cycles, required 2", i, lat);
        end
      end
      vectors++;
      if (viol != 0) begin
        miscompares++;
        $display("FAIL dir%0d_protocol: got %0d violations, required 0", i, viol);
      end
    end
    // Final access must have written back the dirty 0x20 line before refilling 0x10
    vectors++;
    if (obs_q.size() != 2 || obs_q[0] !== {1'b1, 32'h20, 32'h12345678}) begin
      miscompares++;
      $display("FAIL dir_writeback_victim: got %0d txns, first=%h, required writeback addr 00000020 data 12345678",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0);
    end
`ifdef CACHE_STATS_EN
    vectors++;
    if (hit_count_o !== m_hits || miss_count_o !== m_misses) begin
      miscompares++;
      $display("FAIL dir_stats: hits=%0d misses=%0d, required %0d/%0d", hit_count_o, miss_count_o, m_hits, m_misses);
    end
`endif
  endtask

  task automatic test_ack_delay();
    logic [31:0] rd, exp_rd;
    bit          exp_hit, tmo;
    int          lat, viol, exp_lat;
    model_access(1'b0, 32'h12345678, '0, exp_rd, exp_hit);
    exp_lat = 4 + 5 + ((exp_q.size() == 2) ? 6 : 0);
    run_access(1'b0, 32'h12345678, '0, 5, 5, 1'b0, rd, lat, viol, tmo);
    vectors++;
    if (tmo || lat != exp_lat) begin
      miscompares++;
      $display("FAIL ackdly_latency: got %0d (timeout=%b), required %0d", lat, tmo, exp_lat);
    end
    vectors++;
    if (viol != 0) begin
      miscompares++;
      $display("FAIL ackdly_stable: got %0d stability/ready violations, required 0", viol);
    end
    vectors++;
    if (rd !== exp_rd) begin
      miscompares++;
      $display("FAIL ackdly_rdata: got %h, required %h", rd, exp_rd);
    end
    vectors++;
    if (obs_q.size() == 0 || obs_q[obs_q.size()-1].addr !== 32'h12345678) begin
      miscompares++;
      $display("FAIL ackdly_refill_addr: got %0d txns, required refill of 12345678", obs_q.size());
    end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd, exp_rd;
    bit          we, exp_hit, tmo;
    int          lat, viol;
    for (int i = 0; i < 200; i++) begin
      a  = ($urandom_range(3, 0) << 4) | ($urandom_range(3, 0) << 2) | $urandom_range(3, 0);
      we = 1'($urandom_range(1, 0));
      wd = $urandom;
      model_access(we, a, wd, exp_rd, exp_hit);
      run_access(we, a, wd, 0, 3, 1'b1, rd, lat, viol, tmo);
      vectors++;
      if (tmo || viol != 0 || (exp_hit && lat != 2)) begin
        miscompares++;
        $display("FAIL rnd%0d_timing: timeout=%b violations=%0d latency=%0d, required 0/0 and 2 on hit (hit=%b)",
                 i, tmo, viol, lat, exp_hit);
      end
      vectors++;
      if (obs_q.size() != exp_q.size()) begin
        miscompares++;
        $display("FAIL rnd%0d_txn_count: got %0d, required %0d (addr %h)", i, obs_q.size(), exp_q.size(), a);
      end else begin
        foreach (exp_q[k]) begin
          vectors++;
          if (obs_q[k].we !== exp_q[k].we || obs_q[k].addr !== exp_q[k].addr ||
              (exp_q[k].we && obs_q[k].wdata !== exp_q[k].wdata)) begin
            miscompares++;
            $display("FAIL rnd%0d_txn%0d: got %h, required %h", i, k, obs_q[k], exp_q[k]);
          end
        end
      end
      if (!we) begin
        vectors++;
        if (rd !== exp_rd) begin
          miscompares++;
          $display("FAIL rnd%0d_rdata: got %h, required %h (addr %h)", i, rd, exp_rd, a);
        end
      end
    end
`ifdef CACHE_STATS_EN
    vectors++;
    if (hit_count_o !== m_hits || miss_count_o !== m_misses) begin
      miscompares++;
      $display("FAIL rnd_stats: hits=%0d misses=%0d, required %0d/%0d", hit_count_o, miss_count_o, m_hits, m_misses);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, exp_rd;
    bit          exp_hit, tmo, seen;
    int          lat, viol;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h10;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      if (mem_req_o) seen = 1;
    end
    vectors++;
    if (!seen || mem_we_o !== 1'b0 || mem_addr_o !== 32'h10) begin
      miscompares++;
      $display("FAIL rstmid_refill: seen=%b we=%b addr=%h, required refill of 00000010", seen, mem_we_o, mem_addr_o);
    end
    @(negedge clk); rst = 1'b1; cpu_req_i = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({cpu_ready_o, cpu_rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_outputs: ready=%b req=%b we=%b addr=%h, required all zero",
               cpu_ready_o, mem_req_o, mem_we_o, mem_addr_o);
    end
    @(negedge clk); rst = 1'b0;
    model_access(1'b0, 32'h10, '0, exp_rd, exp_hit);
    run_access(1'b0, 32'h10, '0, 0, 2, 1'b0, rd, lat, viol, tmo);
    vectors++;
    if (tmo || obs_q.size() != 1 || obs_q[0].we !== 1'b0 || obs_q[0].addr !== 32'h10) begin
      miscompares++;
      $display("FAIL rstmid_miss_after: timeout=%b txns=%0d, required a single refill of 00000010", tmo, obs_q.size());
    end
    vectors++;
    if (rd !== exp_rd) begin
      miscompares++;
      $display("FAIL rstmid_rdata: got %h, required %h", rd, exp_rd);
    end
`ifdef CACHE_STATS_EN
    vectors++;
    if (hit_count_o !== 0 || miss_count_o !== 1) begin
      miscompares++;
      $display("FAIL rstmid_stats: hits=%0d misses=%0d, required 0/1", hit_count_o, miss_count_o);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ack_delay();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
